// File: rtl/i2s_master_transmitter_if.sv
// Port bundle for the I2S master transmitter: sample handshake, run control, serial lines, status.
// Latency: none, wires only.
// Backpressure: o_ready is driven by the transmitter; a pair transfers on i_valid && o_ready.
interface i2s_master_transmitter_if #(
    parameter int DATA_W = 24
);
    logic              i_enable;
    logic              i_valid;
    logic              o_ready;
    logic [DATA_W-1:0] i_left_sample;
    logic [DATA_W-1:0] i_right_sample;
    logic              o_bck;
    logic              o_lrck;
    logic              o_serial_data;
    logic              o_frame_start;
    logic              o_underrun;
    logic              o_busy;

    // Transmitter side.
    modport master (
        input  i_enable, i_valid, i_left_sample, i_right_sample,
        output o_ready, o_bck, o_lrck, o_serial_data, o_frame_start, o_underrun, o_busy
    );

    // Sample source / serial receiver side.
    modport slave (
        output i_enable, i_valid, i_left_sample, i_right_sample,
        input  o_ready, o_bck, o_lrck, o_serial_data, o_frame_start, o_underrun, o_busy
    );
endinterface

// File: rtl/i2s_master_transmitter.sv
// I2S master transmitter: generates BCK/LRCK and MSB-first serial data from left/right sample pairs.
// Latency: an accepted pair goes out in the next frame; lrck/data change on the clock BCK rises.
// Backpressure: one-pair holding register, o_ready low while full; starved frames repeat the last pair.
// Build option: define LEFT_JUSTIFIED_EN for left-justified slots (no one-bit delay).
module i2s_master_transmitter #(
    parameter int CLK_DIV    = 4,
    parameter int BCK_PER_CH = 32,
    parameter int DATA_W     = 24
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    i2s_master_transmitter_if.master bus
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(2 * BCK_PER_CH);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * BCK_PER_CH - 1);
    localparam logic [BIT_W-1:0] SLOT_LEN = BIT_W'(BCK_PER_CH);
    localparam logic [BIT_W-1:0] WORD_LEN = BIT_W'(DATA_W);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_STOP} state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;   // position emitted at the next BCK rising event
    logic              bck_q, bck_d;
    logic              lrck_q, lrck_d;
    logic              sdata_q, sdata_d;
    logic              fstart_q, fstart_d;
    logic              under_q, under_d;
    logic              hold_full_q, hold_full_d;
    logic [DATA_W-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
    logic [DATA_W-1:0] sh_l_q, sh_l_d, sh_r_q, sh_r_d;

    logic              bck_rise, frame_edge, stop_now, load, in_right, emit;
    logic [BIT_W-1:0]  slot_pos;
    logic [DATA_W-1:0] src_l, src_r, word, word_rot;

    assign bck_rise   = (state_q != ST_IDLE) && (div_cnt_q == DIV_LAST) && !bck_q;
    assign frame_edge = bck_rise && (bit_cnt_q == '0);
    // In STOP the wrap ends transmission instead of starting a new frame.
    assign stop_now   = frame_edge && (state_q == ST_STOP) && !bus.i_enable;
    assign load       = frame_edge && !stop_now;
    assign in_right   = (bit_cnt_q >= SLOT_LEN);
    assign slot_pos   = in_right ? (bit_cnt_q - SLOT_LEN) : bit_cnt_q;
`ifdef LEFT_JUSTIFIED_EN
    assign emit       = (slot_pos < WORD_LEN);
`else
    assign emit       = (slot_pos != '0) && (slot_pos <= WORD_LEN);
`endif
    // Shift registers rotate rather than shift, so a full slot returns them to the
    // original word; an underrun frame then simply re-sends what they hold.
    assign src_l      = (load && hold_full_q) ? hold_l_q : sh_l_q;
    assign src_r      = (load && hold_full_q) ? hold_r_q : sh_r_q;
    assign word       = in_right ? src_r : src_l;
    assign word_rot   = {word[DATA_W-2:0], word[DATA_W-1]};

    // Run control: IDLE -> RUN on enable, RUN -> STOP on disable, STOP finishes the frame.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (bus.i_enable) state_d = ST_RUN;
            ST_RUN:  if (!bus.i_enable) state_d = ST_STOP;
            ST_STOP: begin
                if (bus.i_enable)  state_d = ST_RUN;
                else if (stop_now) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Clock division, serialisation, frame load and holding-register handshake.
    always_comb begin
        div_cnt_d   = div_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        bck_d       = bck_q;
        lrck_d      = lrck_q;
        sdata_d     = sdata_q;
        fstart_d    = 1'b0;
        under_d     = 1'b0;
        hold_full_d = hold_full_q;
        hold_l_d    = hold_l_q;
        hold_r_d    = hold_r_q;
        sh_l_d      = sh_l_q;
        sh_r_d      = sh_r_q;

        if (state_q != ST_IDLE) begin
            div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
            if (div_cnt_q == DIV_LAST) bck_d = !bck_q;
        end

        if (bck_rise) begin
            bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + 1'b1;
            lrck_d    = in_right;
            sdata_d   = emit & word[DATA_W-1];
            sh_l_d    = src_l;
            sh_r_d    = src_r;
            if (emit) begin
                if (in_right) sh_r_d = word_rot;
                else          sh_l_d = word_rot;
            end
        end

        if (stop_now) begin
            div_cnt_d = '0;
            bit_cnt_d = '0;
            bck_d     = 1'b0;
            lrck_d    = 1'b0;
            sdata_d   = 1'b0;
            sh_l_d    = sh_l_q;
            sh_r_d    = sh_r_q;
        end

        // Load sees the pre-accept holding state; an accept in the same clock stays held.
        if (load) begin
            fstart_d    = 1'b1;
            under_d     = !hold_full_q;
            hold_full_d = 1'b0;
        end

        if (bus.i_valid && !hold_full_q) begin
            hold_l_d    = bus.i_left_sample;
            hold_r_d    = bus.i_right_sample;
            hold_full_d = 1'b1;
        end
    end

    // State and datapath registers; reset discards any held pair and silences the link.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            div_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            bck_q       <= 1'b0;
            lrck_q      <= 1'b0;
            sdata_q     <= 1'b0;
            fstart_q    <= 1'b0;
            under_q     <= 1'b0;
            hold_full_q <= 1'b0;
            hold_l_q    <= '0;
            hold_r_q    <= '0;
            sh_l_q      <= '0;
            sh_r_q      <= '0;
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            bck_q       <= bck_d;
            lrck_q      <= lrck_d;
            sdata_q     <= sdata_d;
            fstart_q    <= fstart_d;
            under_q     <= under_d;
            hold_full_q <= hold_full_d;
            hold_l_q    <= hold_l_d;
            hold_r_q    <= hold_r_d;
            sh_l_q      <= sh_l_d;
            sh_r_q      <= sh_r_d;
        end
    end

    assign bus.o_ready       = !hold_full_q;
    assign bus.o_bck         = bck_q;
    assign bus.o_lrck        = lrck_q;
    assign bus.o_serial_data = sdata_q;
    assign bus.o_frame_start = fstart_q;
    assign bus.o_underrun    = under_q;
    assign bus.o_busy        = (state_q != ST_IDLE);
endmodule

// File: tb/tb_i2s_master_transmitter.sv
// Bench for i2s_master_transmitter: directed steps with random sample pairs.
// A falling-edge monitor captures whole frames and compares them against a frame-level pair model.
// Handshake acceptance is tracked by clock edge so loads and accepts in the same clock are ordered.
`timescale 1ns/1ps
module tb_i2s_master_transmitter;
    localparam int CLK_DIV = 2;
    localparam int BCK     = 32;
    localparam int DW      = 24;
    localparam int FBITS   = 2 * BCK;

    typedef struct packed { logic [DW-1:0] l; logic [DW-1:0] r; } pair_t;
    typedef struct { pair_t p; int tag; } acc_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    i2s_master_transmitter_if #(.DATA_W(DW)) bus ();

    i2s_master_transmitter #(.CLK_DIV(CLK_DIV), .BCK_PER_CH(BCK), .DATA_W(DW)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected serial bit at frame position i for a given pair.
    function automatic logic exp_bit(input pair_t p, input int i);
        int s;
        logic [DW-1:0] w;
        s = i % BCK;
        w = (i >= BCK) ? p.r : p.l;
`ifdef LEFT_JUSTIFIED_EN
        if (s < DW) return w[DW-1-s];
`else
        if (s >= 1 && s <= DW) return w[DW-s];
`endif
        return 1'b0;
    endfunction

    // Frame-level model state.
    acc_t  acc_q[$];
    pair_t last_pair = '0;
    pair_t cur_exp   = '0;
    logic  exp_und   = 1'b0;
    int    edge_n    = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    // Monitor state.
    int idx = -1;
    logic [FBITS-1:0] cap_dat, cap_lr;
    int fs_cnt = 0, done_cnt = 0, dropped = 0;
    int und_cnt = 0, exp_und_cnt = 0, stray_und = 0;
    int last_fs_edge = 0, fs_gap = 0;
    int last_bck_rise = -1, bck_per = 0, last_lrck_rise = -1, lrck_per = 0;
    logic prev_bck = 1'b0, prev_lrck = 1'b0;

    task automatic check_frame();
        logic [FBITS-1:0] ed, el;
        for (int i = 0; i < FBITS; i++) begin
            ed[i] = exp_bit(cur_exp, i);
            el[i] = (i >= BCK);
        end
        chk("frame_data", 64'(cap_dat), 64'(ed));
        chk("frame_lrck", 64'(cap_lr), 64'(el));
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (idx >= 0) dropped++;
            idx = -1;
            prev_bck = 1'b0;
            prev_lrck = 1'b0;
            last_bck_rise = -1;
            last_lrck_rise = -1;
        end else begin
            if (bus.o_underrun && !bus.o_frame_start) stray_und++;
            if (bus.o_frame_start) begin
                fs_cnt++;
                fs_gap = edge_n - last_fs_edge;
                last_fs_edge = edge_n;
                if (acc_q.size() > 0 && acc_q[0].tag < edge_n) begin
                    cur_exp = acc_q[0].p;
                    void'(acc_q.pop_front());
                    exp_und = 1'b0;
                end else begin
                    cur_exp = last_pair;
                    exp_und = 1'b1;
                    exp_und_cnt++;
                end
                last_pair = cur_exp;
                if (bus.o_underrun) und_cnt++;
                chk("underrun_flag", 64'(bus.o_underrun), 64'(exp_und));
                idx = 0;
            end
            if (prev_bck && !bus.o_bck && idx >= 0) begin
                cap_dat[idx] = bus.o_serial_data;
                cap_lr[idx]  = bus.o_lrck;
                idx++;
                if (idx == FBITS) begin
                    check_frame();
                    done_cnt++;
                    idx = -1;
                end
            end
            if (!prev_bck && bus.o_bck) begin
                if (last_bck_rise >= 0) bck_per = edge_n - last_bck_rise;
                last_bck_rise = edge_n;
            end
            if (!prev_lrck && bus.o_lrck) begin
                if (last_lrck_rise >= 0) lrck_per = edge_n - last_lrck_rise;
                last_lrck_rise = edge_n;
            end
            prev_bck  = bus.o_bck;
            prev_lrck = bus.o_lrck;
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic send(input pair_t p, output int acc_edge);
        int n = 0;
        acc_t a;
        bus.i_valid = 1'b1;
        bus.i_left_sample = p.l;
        bus.i_right_sample = p.r;
        while (!bus.o_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        acc_edge = -1;
        if (!bus.o_ready) begin
            chk("send_ready_timeout", 64'(bus.o_ready), 64'd1);
        end else begin
            acc_edge = edge_n + 1;
            a.p = p;
            a.tag = acc_edge;
            acc_q.push_back(a);
        end
        @(negedge clk);
        bus.i_valid = 1'b0;
    endtask

    task automatic wait_fs(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.o_frame_start && n < 1000);
        chk(tag, 64'(bus.o_frame_start), 64'd1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.o_busy && n < 1000);
        chk(tag, 64'(bus.o_busy), 64'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_bck"},   64'(bus.o_bck), 64'd0);
        chk({tag, "_lrck"},  64'(bus.o_lrck), 64'd0);
        chk({tag, "_sdata"}, 64'(bus.o_serial_data), 64'd0);
        chk({tag, "_fs"},    64'(bus.o_frame_start), 64'd0);
        chk({tag, "_und"},   64'(bus.o_underrun), 64'd0);
        chk({tag, "_busy"},  64'(bus.o_busy), 64'd0);
        chk({tag, "_ready"}, 64'(bus.o_ready), 64'd1);
    endtask

    initial begin
        pair_t p1, p2, q;
        int t1, t2, fs_before;

        bus.i_enable = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_left_sample = '0;
        bus.i_right_sample = '0;
        #2 rst = 1'b1;
        wait_clks(3);
        chk_reset_outputs("reset");
        rst = 1'b0;
        wait_clks(1);

        // Preload while idle, then enable.
        p1.l = 24'hA5A5A5;
        p1.r = 24'h5A5A5A;
        send(p1, t1);
        chk("idle_ready_low", 64'(bus.o_ready), 64'd0);
        chk("idle_busy", 64'(bus.o_busy), 64'd0);
        bus.i_enable = 1'b1;
        wait_fs("first_frame");
        chk("first_frame_underrun", 64'(bus.o_underrun), 64'd0);
        chk("run_busy", 64'(bus.o_busy), 64'd1);
        wait_fs("second_frame");
        chk("second_frame_underrun", 64'(bus.o_underrun), 64'd1);
        wait_clks(150);
        chk("bck_period", 64'(bck_per), 64'(2 * CLK_DIV));
        chk("lrck_period", 64'(lrck_per), 64'(2 * BCK * 2 * CLK_DIV));

        // Backpressure: P2 waits for P1 to load.
        p1.l = 24'($urandom());
        p1.r = 24'($urandom());
        p2.l = 24'($urandom());
        p2.r = 24'($urandom());
        wait_fs("bp_sync");
        wait_clks(8);
        send(p1, t1);
        chk("bp_ready_low", 64'(bus.o_ready), 64'd0);
        send(p2, t2);
        chk("bp_p2_accept_edge", 64'(t2), 64'(last_fs_edge + 1));

        // Random stream, one pair per frame.
        for (int k = 0; k < 4; k++) begin
            q.l = (k == 0) ? 24'h800001 : 24'($urandom());
            q.r = 24'($urandom());
            send(q, t1);
        end

        // Disable mid-frame around bit 10.
        wait_fs("dis_sync");
        wait_clks(10 * 2 * CLK_DIV);
        bus.i_enable = 1'b0;
        fs_before = fs_cnt;
        wait_idle("stop_busy");
        chk("stop_bck", 64'(bus.o_bck), 64'd0);
        chk("stop_lrck", 64'(bus.o_lrck), 64'd0);
        chk("stop_sdata", 64'(bus.o_serial_data), 64'd0);
        chk("stop_frame_complete", 64'(done_cnt), 64'(fs_cnt));
        wait_clks(300);
        chk("idle_no_new_frame", 64'(fs_cnt), 64'(fs_before));
        chk("idle_bck_low", 64'(bus.o_bck), 64'd0);

        // Re-enable during STOP: next frame follows with no gap.
        bus.i_enable = 1'b1;
        wait_fs("re_first");
        wait_clks(20 * 2 * CLK_DIV);
        bus.i_enable = 1'b0;
        wait_clks(30 * 2 * CLK_DIV);
        chk("re_stop_busy", 64'(bus.o_busy), 64'd1);
        bus.i_enable = 1'b1;
        wait_fs("re_next");
        wait_clks(1);
        chk("re_frame_gap", 64'(fs_gap), 64'(2 * BCK * 2 * CLK_DIV));

        // Reset mid-frame around bit 40.
        q.l = 24'($urandom());
        q.r = 24'($urandom());
        send(q, t1);
        wait_fs("rst_sync");
        wait_clks(40 * 2 * CLK_DIV + 1);
        rst = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        acc_q.delete();
        last_pair = '0;
        bus.i_enable = 1'b0;
        wait_clks(3);
        rst = 1'b0;
        wait_clks(1);
        bus.i_enable = 1'b1;
        wait_fs("post_rst_frame");
        chk("post_rst_underrun", 64'(bus.o_underrun), 64'd1);
        wait_fs("post_rst_frame2");

        // Wind down and reconcile totals.
        bus.i_enable = 1'b0;
        wait_idle("final_idle");
        wait_clks(4);
        chk("frames_accounted", 64'(done_cnt + dropped), 64'(fs_cnt));
        chk("underrun_count", 64'(und_cnt), 64'(exp_und_cnt));
        chk("stray_underrun", 64'(stray_und), 64'd0);
        chk("model_queue_empty", 64'(acc_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
